ahb_mem_slave: RTL and testbench
================================

Name: ahb_mem_slave

Overview:
- AHB-Lite responder: an 8-bit single-port memory slave with programmable wait states and an ERROR response for out-of-range addresses.
- Sits on the slave side of the AHB2AHB bridge fabric; one instance backs each memory region (memos0/memos1) driven by the bridge master.
- Completes the other end of the bridge's address/data/write/hready handshake.

Parameters:
- ADDR_W, 11, haddr width
- DATA_W, 8, data bus width
- DEPTH, 1024, implemented bytes; addresses >= DEPTH get an ERROR response
- WAIT_STATES, 1, hreadyout low cycles inserted per OKAY data phase (0..7)

Ports:
- hclk  in  1  bus clock, rising edge
- resetn  in  1  asynchronous active-low reset
- hsel  in  1  slave select from decoder
- haddr  in  ADDR_W  transfer address (byte)
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- hwrite  in  1  1 = write, 0 = read
- hready_in  in  1  global HREADY (end of previous data phase)
- hwdata  in  DATA_W  write data, valid in data phase
- hrdata  out  DATA_W  read data
- hreadyout  out  1  slave ready, low = wait
- hresp  out  1  0 OKAY, 1 ERROR

Behaviour:
- Reset (async, resetn=0): hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0. Memory contents are not cleared. Reset mid-transfer aborts it; a pending write is discarded.
- Address phase accepted on a rising edge when hsel & htrans[1] & hready_in. On acceptance, register haddr, hwrite and err = (haddr >= DEPTH).
- IDLE/BUSY, or hsel=0, with hready_in=1: no transfer. The slave stays in IDLE with hreadyout=1, hresp=0.
- FSM states:
  - IDLE: accepted OKAY transfer -> WAIT if WAIT_STATES>0, else DATA; accepted err transfer -> ERR1.
  - WAIT: hreadyout=0, hresp=0; counter counts to WAIT_STATES, then -> DATA.
  - DATA: hreadyout=1, hresp=0. A write stores hwdata at the registered address on this cycle's closing edge. A read drives hrdata = mem[addr] this cycle. A new accepted address phase on the same edge -> WAIT/DATA/ERR1 (pipelined back-to-back); otherwise -> IDLE.
  - ERR1: hreadyout=0, hresp=1 -> ERR2.
  - ERR2: hreadyout=1, hresp=1; no memory access. Next state is decided as in DATA.
- Latency (single-transfer completion):
  - OKAY: WAIT_STATES+1 cycles after address-phase acceptance.
  - ERROR: always 2 cycles.
- hrdata holds its last read value outside read data phases; writes never change hrdata.
- Read-after-write to the same address, back to back with WAIT_STATES=0: the read returns the newly written value. Forward hwdata if the array read is registered.
- Address is not wrapped: haddr in [DEPTH, 2^ADDR_W-1] always ERRORs, for both read and write.
- A master cancelling after ERR1 (htrans=IDLE during ERR2) is legal; the slave returns to IDLE.
- While hreadyout=0, the address and control on the bus are ignored: no acceptance, since hready_in is low.

Test Plan:
- Reset release, bus idle (htrans=00, hsel=1): hreadyout=1, hresp=0, hrdata=8'h00 every cycle.
- WAIT_STATES=1:
  - Write 8'hA5 to 11'h010: hreadyout low exactly 1 cycle, then high with hresp=0.
  - Read of 11'h010: hrdata=8'hA5 on the cycle hreadyout=1 (2 cycles after address).
- WAIT_STATES=0, back-to-back NONSEQ:
  - Write 8'h3C @11'h020, read @11'h020, write 8'h5A @11'h3FF, read @11'h3FF: zero wait cycles.
  - Reads return 8'h3C and 8'h5A.
- Read @11'h400 with DEPTH=1024:
  - Cycle 1: hreadyout=0, hresp=1. Cycle 2: hreadyout=1, hresp=1.
  - A following write 8'hFF to 11'h400 also ERRORs, and mem[0] is unchanged on readback.
- WAIT_STATES=3, write 8'h77 @11'h005, resetn pulsed low during the 2nd wait cycle:
  - Outputs go to reset values immediately.
  - After reset, a read @11'h005 does not return 8'h77 (pre-loaded 8'h11 is returned).
- hsel=0 with htrans=10 and hready_in=1 for 5 cycles: no state change, hreadyout=1, memory unchanged.

Source files
------------

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory responder: byte-wide single-port array with programmable wait
// states and a two-cycle ERROR response for addresses beyond the implemented depth.
module ahb_mem_slave #(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              hclk,
  input  logic              resetn,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic              hready_in,
  input  logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp
);

  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_STATES);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic              r_err;
  logic              r_hreadyout;
  logic              r_hresp;
  logic [DATA_W-1:0] r_hrdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [2:0]        w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_hreadyout_nxt;
  logic              w_hresp_nxt;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_accept;
  logic              w_addr_err;

  // Only NONSEQ/SEQ start a transfer, and never while this slave is stalling.
  assign w_accept   = hsel & hready_in & r_hreadyout & ((htrans == 2'b10) | (htrans == 2'b11));
  assign w_addr_err = (32'(haddr) >= DEPTH);

  // Read data is captured on entry to DATA; a write finishing in the same edge is forwarded.
  assign w_rd_data = (r_state == S_DATA && r_write && r_addr == w_rd_addr) ?
                     hwdata : r_mem[w_rd_addr[MEM_AW-1:0]];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rd_en     = 1'b0;
    w_rd_addr   = haddr;
    case (r_state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (w_accept) begin
          if (w_addr_err) begin
            w_state_nxt = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_W'(1);
          end else begin
            w_state_nxt = S_DATA;
            w_rd_en     = ~hwrite;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        w_rd_addr = r_addr;
        if (r_cnt >= WAIT_LAST) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
          w_rd_en     = ~r_write;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_ERR1:  w_state_nxt = S_ERR2;
      default: w_state_nxt = S_IDLE;
    endcase
    w_hreadyout_nxt = (w_state_nxt != S_WAIT) && (w_state_nxt != S_ERR1);
    w_hresp_nxt     = (w_state_nxt == S_ERR1) || (w_state_nxt == S_ERR2);
  end

  always_ff @(posedge hclk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_err       <= 1'b0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_hrdata    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hreadyout <= w_hreadyout_nxt;
      r_hresp     <= w_hresp_nxt;
      if (w_accept) begin
        r_addr  <= haddr;
        r_write <= hwrite;
        r_err   <= w_addr_err;
      end
      if (w_rd_en) begin
        r_hrdata <= w_rd_data;
      end
    end
  end

  // Array is not reset; a write lands on the closing edge of its DATA cycle.
  always_ff @(posedge hclk) begin
    if (r_state == S_DATA && r_write && !r_err) begin
      r_mem[r_addr[MEM_AW-1:0]] <= hwdata;
    end
  end

  assign hrdata    = r_hrdata;
  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Scoreboard bench for ahb_mem_slave: three instances (0, 1 and 3 wait states)
// share one bus; a per-instance byte array is the reference memory.
module tb_ahb_mem_slave;

  typedef struct {
    bit         err;
    bit         rd;
    logic [7:0] data;
    int         waits;
  } sb_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        hsel_v = 1'b0;
  logic [10:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [7:0]  hwdata = '0;
  int          sel = 0;

  logic [7:0]  rd0, rd1, rd2;
  logic        rdy0, rdy1, rdy2;
  logic        resp0, resp1, resp2;
  logic [7:0]  cur_rdata;
  logic        cur_ready, cur_resp;

  int          ws_of [3] = '{0, 1, 3};
  logic [7:0]  mmem [3][1024];
  logic [7:0]  last_rd [3] = '{8'h00, 8'h00, 8'h00};
  sb_t         sb [$];
  sb_t         e;
  bit          in_dp = 1'b0;
  int          wc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  ahb_mem_slave #(.WAIT_STATES(0)) u_ws0 (
    .hclk(clk), .resetn(resetn), .hsel(hsel_v && sel == 0), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hready_in(rdy0), .hwdata(hwdata),
    .hrdata(rd0), .hreadyout(rdy0), .hresp(resp0));
  ahb_mem_slave #(.WAIT_STATES(1)) u_ws1 (
    .hclk(clk), .resetn(resetn), .hsel(hsel_v && sel == 1), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hready_in(rdy1), .hwdata(hwdata),
    .hrdata(rd1), .hreadyout(rdy1), .hresp(resp1));
  ahb_mem_slave #(.WAIT_STATES(3)) u_ws3 (
    .hclk(clk), .resetn(resetn), .hsel(hsel_v && sel == 2), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hready_in(rdy2), .hwdata(hwdata),
    .hrdata(rd2), .hreadyout(rdy2), .hresp(resp2));

  assign cur_rdata = (sel == 0) ? rd0 : (sel == 1) ? rd1 : rd2;
  assign cur_ready = (sel == 0) ? rdy0 : (sel == 1) ? rdy1 : rdy2;
  assign cur_resp  = (sel == 0) ? resp0 : (sel == 1) ? resp1 : resp2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (dut %0d, t=%0t): got %0h expected %0h", nm, sel, $time, act, exp);
  endtask

  // Monitor: tracks the selected slave's data phase and pops one expectation per completion.
  always @(negedge clk) begin
    logic [7:0] exp_rd;
    if (!resetn) begin
      in_dp = 1'b0;
      wc = 0;
      sb.delete();
    end else begin
      exp_rd = last_rd[sel];
      if (in_dp) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 32'd1);
          in_dp = 1'b0;
        end else begin
          e = sb[0];
          if (cur_ready) begin
            chk("resp", 32'(cur_resp), 32'(e.err));
            chk("wait_cycles", 32'(wc), 32'(e.waits));
            if (e.rd && !e.err) begin
              exp_rd = e.data;
              last_rd[sel] = e.data;
            end
            void'(sb.pop_front());
            in_dp = 1'b0;
          end else begin
            wc++;
            chk("wait_resp", 32'(cur_resp), 32'(e.err));
            if (wc > 40) begin
              $display("FAIL data_phase_timeout: got %0d wait cycles expected %0d", wc, e.waits);
              $fatal(1, "data phase never completed");
            end
          end
        end
      end else begin
        chk("idle_ready_resp", {30'd0, cur_ready, cur_resp}, 32'b10);
      end
      chk("hrdata", 32'(cur_rdata), 32'(exp_rd));
      if (hsel_v && htrans[1] && cur_ready) begin
        in_dp = 1'b1;
        wc = 0;
      end
    end
  end

  // Issues one NONSEQ transfer; called just after a rising edge, returns just after the next one.
  task automatic issue(input bit wr, input int unsigned addr, input logic [7:0] d);
    sb_t x;
    int g = 0;
    hsel_v = 1'b1; htrans = 2'b10; hwrite = wr; haddr = 11'(addr);
    @(negedge clk);
    while (!cur_ready) begin
      g++;
      if (g > 40) begin
        $display("FAIL accept_timeout: got hreadyout low for %0d cycles expected at most %0d", g, 40);
        $fatal(1, "address phase never accepted");
      end
      @(negedge clk);
    end
    x.err = (addr >= 1024);
    x.rd = !wr;
    x.waits = x.err ? 1 : ws_of[sel];
    if (!x.err && wr) mmem[sel][addr] = d;
    x.data = x.err ? 8'h00 : mmem[sel][addr];
    sb.push_back(x);
    @(posedge clk); #1;
    hwdata = wr ? d : 8'($urandom);
    htrans = 2'b00;
  endtask

  // Bus activity that must not start a transfer: IDLE, BUSY, or NONSEQ with hsel low.
  task automatic gap(input int n, input int kind, input int unsigned addr);
    case (kind)
      0: begin hsel_v = 1'b1; htrans = 2'b00; end
      1: begin hsel_v = 1'b1; htrans = 2'b01; end
      default: begin hsel_v = 1'b0; htrans = 2'b10; hwrite = 1'b1; haddr = 11'(addr); end
    endcase
    repeat (n) begin @(posedge clk); #1; end
    hsel_v = 1'b1; htrans = 2'b00;
  endtask

  task automatic random_run(input int s);
    int unsigned a;
    sel = s;
    for (int i = 0; i < 24; i++) begin
      a = (i < 16) ? i : 1000 + i;
      issue(1'b1, a, 8'($urandom));
    end
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 2) a = 1024 + $urandom_range(0, 1023);
      else begin
        a = $urandom_range(0, 23);
        if (a >= 16) a = a + 1000;
      end
      issue(1'($urandom), a, 8'($urandom));
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2), $urandom_range(0, 2), $urandom_range(0, 2047));
    end
    gap(6, 0, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    hsel_v = 1'b1;
    gap(4, 0, 0);

    sel = 1;
    issue(1'b1, 11'h010, 8'hA5);
    issue(1'b0, 11'h010, 8'h00);
    gap(3, 0, 0);

    sel = 0;
    issue(1'b1, 11'h020, 8'h3C);
    issue(1'b0, 11'h020, 8'h00);
    issue(1'b1, 11'h3FF, 8'h5A);
    issue(1'b0, 11'h3FF, 8'h00);
    gap(3, 0, 0);

    sel = 1;
    issue(1'b1, 11'h000, 8'h42);
    gap(2, 0, 0);
    issue(1'b0, 11'h400, 8'h00);
    issue(1'b1, 11'h400, 8'hFF);
    issue(1'b0, 11'h000, 8'h00);
    gap(2, 0, 0);
    gap(5, 2, 0);
    issue(1'b0, 11'h000, 8'h00);
    gap(3, 0, 0);

    for (int s = 0; s < 3; s++) random_run(s);

    // Reset in the middle of a 3-wait-state write must discard it.
    sel = 2;
    issue(1'b1, 11'h005, 8'h11);
    gap(6, 0, 0);
    hsel_v = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 11'h005;
    @(negedge clk);
    chk("pre_abort_ready", 32'(cur_ready), 32'd1);
    sb.push_back('{err: 1'b0, rd: 1'b0, data: 8'h00, waits: 3});
    @(posedge clk); #1;
    htrans = 2'b00; hwdata = 8'h77;
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("reset_hreadyout", 32'(cur_ready), 32'd1);
    chk("reset_hresp", 32'(cur_resp), 32'd0);
    chk("reset_hrdata", 32'(cur_rdata), 32'd0);
    for (int k = 0; k < 3; k++) last_rd[k] = 8'h00;
    @(posedge clk); #2;
    resetn = 1'b1;
    @(posedge clk); #1;
    gap(2, 0, 0);
    issue(1'b0, 11'h005, 8'h00);
    gap(6, 0, 0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
